// File: rtl/prom_dump_pkg.sv
// Shared types and sizing for the 32x2 PROM dump block.
package prom_dump_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int NUM_WORDS      = 32;
    localparam int WORDS_PER_BYTE = 4;
    localparam int NUM_BYTES      = 8;
    localparam int ADDR_W         = $clog2(NUM_WORDS);

endpackage

// File: rtl/prom_dump_if.sv
// Control, PROM and byte-stream signals of prom_dump, grouped as one bundle.
interface prom_dump_if;
    import prom_dump_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              prom_ce_n;
    logic [ADDR_W-1:0] prom_a;
    logic [1:0]        prom_d;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic [7:0]        checksum;

    modport master (
        input  start, prom_d, byte_ready,
        output busy, done, prom_ce_n, prom_a, byte_data, byte_valid, checksum
    );

    modport slave (
        output start, prom_d, byte_ready,
        input  busy, done, prom_ce_n, prom_a, byte_data, byte_valid, checksum
    );

endinterface

// File: rtl/prom_dump_pack.sv
// Packs successive 2-bit PROM words into a byte, first word ending up in bits [1:0].
module prom_dump_pack (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [1:0] din,
    output logic [7:0] dout
);

    logic [7:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (load) begin
            sr <= {din, sr[7:2]};
        end
    end

    assign dout = sr;

endmodule

// File: rtl/prom_dump.sv
// Scans a 32x2 PROM word by word and streams its contents as 8 packed bytes plus a checksum.
module prom_dump
    import prom_dump_pkg::*;
#(
    parameter int ACCESS_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    prom_dump_if.master bus
);

    localparam logic [3:0] ACC_LAST   = 4'(ACCESS_CYCLES - 1);
    localparam logic [5:0] WORD_LAST  = 6'(NUM_WORDS - 1);
    localparam logic [5:0] WORD_END   = 6'(NUM_WORDS);
    localparam logic [1:0] BYTE_LAST  = 2'(WORDS_PER_BYTE - 1);

    state_t            state;
    logic [5:0]        word_cnt;   // one bit wider than the address so 31 never wraps to 0 mid-scan
    logic [3:0]        acc_cnt;
    logic              ce_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic [7:0]        csum_q;
    logic [7:0]        pack_q;
    logic              capture;
    logic              pack_clr;

    assign capture  = (state == WAIT) && (acc_cnt == ACC_LAST);
    assign pack_clr = (state == IDLE) && bus.start;

    prom_dump_pack u_pack (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pack_clr),
        .load  (capture),
        .din   (bus.prom_d),
        .dout  (pack_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            word_cnt <= '0;
            acc_cnt  <= '0;
            ce_n_q   <= 1'b1;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            csum_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    ce_n_q  <= 1'b1;
                    addr_q  <= '0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        state    <= WAIT;
                        word_cnt <= '0;
                        acc_cnt  <= '0;
                        csum_q   <= '0;
                        busy_q   <= 1'b1;
                        ce_n_q   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (capture) begin
                        acc_cnt  <= '0;
                        word_cnt <= word_cnt + 6'd1;
                        addr_q   <= (word_cnt == WORD_LAST) ? addr_q : word_cnt[ADDR_W-1:0] + 5'd1;
                        if (word_cnt[1:0] == BYTE_LAST) begin
                            state   <= EMIT;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        acc_cnt <= acc_cnt + 4'd1;
                    end
                end
                EMIT: begin
                    // Everything stays frozen until the consumer takes the byte.
                    if (bus.byte_ready) begin
                        valid_q <= 1'b0;
                        csum_q  <= csum_q + pack_q;
                        if (word_cnt == WORD_END) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            ce_n_q <= 1'b1;
                            addr_q <= '0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    word_cnt <= '0;
                end
                default: begin
                    state    <= IDLE;
                    word_cnt <= '0;
                    acc_cnt  <= '0;
                    ce_n_q   <= 1'b1;
                    addr_q   <= '0;
                    busy_q   <= 1'b0;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.prom_ce_n  = ce_n_q;
    assign bus.prom_a     = addr_q;
    assign bus.byte_data  = pack_q;
    assign bus.byte_valid = valid_q;
    assign bus.checksum   = csum_q;

endmodule

// File: tb/tb_prom_dump.sv
// Bench for prom_dump: Nascom 2 video PROM scenarios, random PROM/ready runs, reset and ACCESS_CYCLES=1.
module tb_prom_dump;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    prom_dump_if bus3 ();
    prom_dump_if bus1 ();

    prom_dump #(.ACCESS_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    prom_dump #(.ACCESS_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus1.prom_d     = 2'b00;
    assign bus1.byte_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int stall_byte;
        int stall_len;
        int rep_a;
        int rep_b;
        int exp_done;
    } scen_t;

    scen_t      tbl [5];
    logic [7:0] nas_b [8] = '{8'hF1, 8'hFF, 8'h7F, 8'hD5, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    logic [1:0] mem [32];
    logic [7:0] exp_b [8];
    logic [7:0] exp_cs;
    logic [7:0] got [$];
    logic [7:0] got1 [$];
    logic [7:0] cs_done;
    logic [4:0] last_a;
    logic       last_ce;
    int done_cnt, done_at, since, stalls, stall_cnt, ce_viol, run, idx;
    int ready_mode, stall_byte, stall_len;
    int acc_cnt [32];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_nascom();
        for (int a = 0; a < 32; a++)
            mem[a] = (a == 0 || a == 31 || (a >= 11 && a <= 14)) ? 2'd1 : (a == 1 ? 2'd0 : 2'd3);
    endtask

    // Reference: byte k is the base-4 number whose digits are words 4k..4k+3, least significant first.
    task automatic build_model();
        int tot;
        tot = 0;
        for (int k = 0; k < 8; k++) begin
            int s;
            s = 0;
            for (int j = 0; j < 4; j++) s += int'(mem[4*k+j]) * (4 ** j);
            exp_b[k] = s[7:0];
            tot += s;
        end
        exp_cs = tot[7:0];
    endtask

    // PROM model with access time, consumer model, and scan bookkeeping, all on the falling edge.
    always @(negedge clk) begin
        if (!bus3.prom_ce_n) begin
            if (last_ce && bus3.prom_a == last_a) run++;
            else run = 1;
        end else begin
            run = 0;
        end
        last_ce = !bus3.prom_ce_n;
        last_a  = bus3.prom_a;
        bus3.prom_d = (run >= 3) ? mem[bus3.prom_a] : ~mem[bus3.prom_a];

        if (ready_mode == 1) begin
            bus3.byte_ready = ($urandom_range(0, 3) != 0);
        end else if (bus3.byte_valid && got.size() == stall_byte && stall_cnt < stall_len) begin
            bus3.byte_ready = 1'b0;
            stall_cnt++;
        end else begin
            bus3.byte_ready = 1'b1;
        end

        if (bus3.byte_valid) begin
            if (bus3.byte_ready) begin
                got.push_back(bus3.byte_data);
            end else begin
                stalls++;
                idx = got.size();
                if (idx < 8) begin
                    chk("stall_hold_data", bus3.byte_data, exp_b[idx]);
                    chk("stall_hold_addr", bus3.prom_a, (idx < 7) ? 4 * (idx + 1) : 31);
                end
            end
        end

        if (bus3.start && !bus3.busy && !bus3.done) since = 0;
        else since++;
        if (bus3.done) begin
            if (done_cnt == 0) begin
                done_at = since;
                cs_done = bus3.checksum;
            end
            done_cnt++;
        end
        if (bus3.busy == bus3.prom_ce_n) ce_viol++;
        if (!bus3.prom_ce_n && !bus3.byte_valid) acc_cnt[bus3.prom_a]++;
    end

    task automatic clear_scan();
        got.delete();
        done_cnt  = 0;
        stalls    = 0;
        stall_cnt = 0;
        ce_viol   = 0;
        for (int a = 0; a < 32; a++) acc_cnt[a] = 0;
    endtask

    task automatic run_scan(input string tag, input int rep_a, input int rep_b, input int exp_done_in);
        int exp_done;
        clear_scan();
        @(posedge clk); #1 bus3.start = 1'b1;
        for (int c = 1; c <= 800 && done_cnt == 0; c++) begin
            @(posedge clk); #1 bus3.start = (c == rep_a) || (c == rep_b);
        end
        bus3.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp_done = (exp_done_in < 0) ? 105 + stalls : exp_done_in;
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_at, exp_done);
        chk({tag, " byte_count"}, got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            chk($sformatf("%s byte%0d", tag, k), got[k], exp_b[k]);
        chk({tag, " checksum_at_done"}, cs_done, exp_cs);
        chk({tag, " checksum_held"}, bus3.checksum, exp_cs);
        chk({tag, " busy_after"}, bus3.busy, 0);
        chk({tag, " ce_vs_busy"}, ce_viol, 0);
        for (int a = 0; a < 32; a++)
            chk($sformatf("%s wait_cycles_a%0d", tag, a), acc_cnt[a], 3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, d1_at, d1_cnt;
        tbl[0] = '{-1, 0, -1, -1, 105};
        tbl[1] = '{3, 20, -1, -1, 125};
        tbl[2] = '{-1, 0, 5, 50, 105};
        tbl[3] = '{7, 3, -1, -1, 108};
        tbl[4] = '{0, 1, 20, 106, 106};

        bus3.start = 1'b0;
        bus1.start = 1'b0;
        ready_mode = 0;
        stall_byte = -1;
        stall_len  = 0;
        load_nascom();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ce_n", bus3.prom_ce_n, 1);
        chk("rst prom_a", bus3.prom_a, 0);
        chk("rst busy", bus3.busy, 0);
        chk("rst done", bus3.done, 0);
        chk("rst byte_valid", bus3.byte_valid, 0);
        chk("rst byte_data", bus3.byte_data, 0);
        chk("rst checksum", bus3.checksum, 0);
        chk("rst dut1 ce_n", bus1.prom_ce_n, 1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 8; k++) exp_b[k] = nas_b[k];
            exp_cs     = 8'hC0;
            ready_mode = 0;
            stall_byte = tbl[i].stall_byte;
            stall_len  = tbl[i].stall_len;
            run_scan($sformatf("tbl%0d", i), tbl[i].rep_a, tbl[i].rep_b, tbl[i].exp_done);
        end

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 32; a++) mem[a] = 2'($urandom_range(0, 3));
            build_model();
            ready_mode = 1;
            stall_byte = -1;
            run_scan($sformatf("rnd%0d", r), int'($urandom_range(2, 100)), int'($urandom_range(2, 100)), -1);
        end

        load_nascom();
        for (int k = 0; k < 8; k++) exp_b[k] = nas_b[k];
        exp_cs     = 8'hC0;
        ready_mode = 0;
        stall_byte = -1;
        clear_scan();
        @(posedge clk); #1 bus3.start = 1'b1;
        @(posedge clk); #1 bus3.start = 1'b0;
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            @(posedge clk); #1;
            if (bus3.prom_a == 5'd13) found = 1;
        end
        chk("mid_rst reached_a13", found, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst ce_n", bus3.prom_ce_n, 1);
        chk("mid_rst prom_a", bus3.prom_a, 0);
        chk("mid_rst busy", bus3.busy, 0);
        chk("mid_rst done", bus3.done, 0);
        chk("mid_rst byte_valid", bus3.byte_valid, 0);
        chk("mid_rst byte_data", bus3.byte_data, 0);
        chk("mid_rst checksum", bus3.checksum, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst bytes_before", got.size(), 3);
        chk("mid_rst no_done", done_cnt, 0);
        chk("mid_rst idle_busy", bus3.busy, 0);
        run_scan("after_rst", -1, -1, 105);

        got1.delete();
        d1_at  = -1;
        d1_cnt = 0;
        @(posedge clk); #1 bus1.start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1 bus1.start = 1'b0;
            if (bus1.byte_valid) got1.push_back(bus1.byte_data);
            if (bus1.done) begin
                if (d1_cnt == 0) d1_at = c;
                d1_cnt++;
            end
        end
        chk("ac1 done_cycle", d1_at, 41);
        chk("ac1 done_pulses", d1_cnt, 1);
        chk("ac1 byte_count", got1.size(), 8);
        for (int k = 0; k < 8 && k < got1.size(); k++)
            chk($sformatf("ac1 byte%0d", k), got1[k], 0);
        chk("ac1 checksum", bus1.checksum, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
